// File: rtl/clock_pkg.sv
// Shared definitions for the clock's piezo sound engine: note codes, tone limits,
// the alarm melody ROM, the player state encoding and the song indicator encoding.
package clock_pkg;

   typedef enum logic [2:0] {
      NOTE_REST = 3'd0,
      NOTE_HI   = 3'd1,
      NOTE_MI   = 3'd2,
      NOTE_RE   = 3'd3,
      NOTE_DO   = 3'd4
   } note_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_A_TONE,
      ST_A_GAP,
      ST_A_MUTE,
      ST_T_TONE,
      ST_T_GAP
   } state_t;

   typedef enum logic [1:0] {
      SONG_NONE  = 2'd0,
      SONG_ALARM = 2'd1,
      SONG_TIMER = 2'd2,
      SONG_MUTED = 2'd3
   } song_t;

   // Half-period of a note is limit+1 cycles, giving 500/(limit+1) Hz at 1 kHz.
   function automatic logic [1:0] tone_limit(input note_t note);
      logic [1:0] limit;
      limit = 2'd0;
      case (note)
         NOTE_HI: limit = 2'd0;
         NOTE_MI: limit = 2'd1;
         NOTE_RE: limit = 2'd2;
         NOTE_DO: limit = 2'd3;
         default: limit = 2'd0;
      endcase
      return limit;
   endfunction

   function automatic note_t melody_note(input logic [4:0] idx);
      note_t n;
      n = NOTE_REST;
      case (idx)
         5'd0, 5'd4, 5'd5, 5'd6, 5'd10, 5'd11, 5'd12, 5'd13,
         5'd17, 5'd18, 5'd19, 5'd22:                     n = NOTE_MI;
         5'd1, 5'd3, 5'd7, 5'd8, 5'd9, 5'd14, 5'd16,
         5'd20, 5'd21, 5'd23:                            n = NOTE_RE;
         5'd2, 5'd15, 5'd24:                             n = NOTE_DO;
         default:                                        n = NOTE_REST;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator for the piezo pin: toggles every tone_limit+1 cycles while a
// note is selected, and is forced low and restarted on REST or a new phase.
module piezo_tone_gen
   import clock_pkg::*;
(
   input  logic  clk_1k,
   input  logic  rst_n,
   input  note_t note,
   input  logic  phase_start,
   output logic  piezo
);

   logic [1:0] tone_cnt_reg, tone_cnt_next;
   logic       piezo_reg, piezo_next;
   logic [1:0] limit;

   assign limit = tone_limit(note);

   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         tone_cnt_reg <= 2'd0;
         piezo_reg    <= 1'b0;
      end else begin
         tone_cnt_reg <= tone_cnt_next;
         piezo_reg    <= piezo_next;
      end
   end

   // note and phase_start describe the phase that begins after this edge.
   always_comb begin
      tone_cnt_next = tone_cnt_reg;
      piezo_next    = piezo_reg;
      if (phase_start || note == NOTE_REST) begin
         tone_cnt_next = 2'd0;
         piezo_next    = 1'b0;
      end else if (tone_cnt_reg == limit) begin
         tone_cnt_next = 2'd0;
         piezo_next    = ~piezo_reg;
      end else begin
         tone_cnt_next = tone_cnt_reg + 2'd1;
      end
   end

   assign piezo = piezo_reg;

endmodule

// File: rtl/piezo_melody_player.sv
// Arbitrated piezo engine: plays the alarm melody while the alarm rings and a short
// beep burst when the timer expires; the alarm always preempts the timer burst.
module piezo_melody_player
   import clock_pkg::*;
#(
   parameter int MELODY_LEN = 25,
   parameter int NOTE_MS    = 500,
   parameter int BEEP_MS    = 250,
   parameter int BEEP_COUNT = 3
) (
   input  logic       clk_1k,
   input  logic       rst_n,
   input  logic       alarm_ring,
   input  logic       timer_done,
   input  logic       stop,
   output logic       piezo,
   output logic       busy,
   output logic [1:0] song,
   output logic [4:0] note_idx
);

   localparam int MAX_MS = (NOTE_MS > BEEP_MS) ? NOTE_MS : BEEP_MS;
   localparam int CNT_W  = $clog2(MAX_MS + 1);
   localparam int BEEP_W = $clog2(BEEP_COUNT + 1);
   localparam logic [CNT_W-1:0]  NOTE_LAST  = CNT_W'(NOTE_MS - 1);
   localparam logic [CNT_W-1:0]  BEEP_LAST  = CNT_W'(BEEP_MS - 1);
   localparam logic [BEEP_W-1:0] BEEP_TOTAL = BEEP_W'(BEEP_COUNT);
   localparam logic [4:0]        IDX_LAST   = 5'(MELODY_LEN - 1);

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [4:0]        idx_reg, idx_next;
   logic [BEEP_W-1:0] beep_reg, beep_next, beep_inc;
   logic              note_done, beep_done, phase_start, timed;
   note_t             note_sel;
   song_t             song_sel;

   assign note_done = (cnt_reg == NOTE_LAST);
   assign beep_done = (cnt_reg == BEEP_LAST);
   assign beep_inc  = beep_reg + BEEP_W'(1);
   assign timed     = (state_reg == ST_A_TONE) || (state_reg == ST_A_GAP) ||
                      (state_reg == ST_T_TONE) || (state_reg == ST_T_GAP);

   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         beep_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         beep_reg  <= beep_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      beep_next  = beep_reg;
      case (state_reg)
         ST_IDLE: begin
            idx_next  = '0;
            beep_next = '0;
            if (alarm_ring)      state_next = ST_A_TONE;
            else if (timer_done) state_next = ST_T_TONE;
         end
         ST_A_TONE: begin
            if (!alarm_ring)     state_next = ST_IDLE;
            else if (stop)       state_next = ST_A_MUTE;
            else if (note_done)  state_next = ST_A_GAP;
         end
         ST_A_GAP: begin
            if (!alarm_ring)     state_next = ST_IDLE;
            else if (stop)       state_next = ST_A_MUTE;
            else if (note_done) begin
               state_next = ST_A_TONE;
               idx_next   = (idx_reg == IDX_LAST) ? 5'd0 : idx_reg + 5'd1;
            end
         end
         ST_A_MUTE: begin
            if (!alarm_ring)     state_next = ST_IDLE;
         end
         ST_T_TONE: begin
            if (alarm_ring) begin
               state_next = ST_A_TONE;
               idx_next   = '0;
            end else if (stop)   state_next = ST_IDLE;
            else if (beep_done)  state_next = ST_T_GAP;
         end
         ST_T_GAP: begin
            if (alarm_ring) begin
               state_next = ST_A_TONE;
               idx_next   = '0;
            end else if (stop)   state_next = ST_IDLE;
            else if (beep_done) begin
               beep_next  = beep_inc;
               state_next = (beep_inc == BEEP_TOTAL) ? ST_IDLE : ST_T_TONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // Every phase in this machine is a distinct state, so a state change marks entry.
      phase_start = (state_next != state_reg);
      if (phase_start || !timed) cnt_next = '0;
      else                       cnt_next = cnt_reg + CNT_W'(1);
   end

   always_comb begin
      busy     = (state_reg != ST_IDLE);
      song_sel = SONG_NONE;
      note_idx = 5'd0;
      case (state_reg)
         ST_A_TONE, ST_A_GAP: begin
            song_sel = SONG_ALARM;
            note_idx = idx_reg;
         end
         ST_A_MUTE: begin
            song_sel = SONG_MUTED;
            note_idx = idx_reg;
         end
         ST_T_TONE, ST_T_GAP: song_sel = SONG_TIMER;
         default:             song_sel = SONG_NONE;
      endcase
      song = song_sel;

      case (state_next)
         ST_A_TONE: note_sel = melody_note(idx_next);
         ST_T_TONE: note_sel = NOTE_HI;
         default:   note_sel = NOTE_REST;
      endcase
   end

   piezo_tone_gen u_tone_gen (
      .clk_1k      (clk_1k),
      .rst_n       (rst_n),
      .note        (note_sel),
      .phase_start (phase_start),
      .piezo       (piezo)
   );

endmodule
